rf_scoreboard: RTL and testbench

- Tracks pending writes to the 32-entry register file so the issue stage never reads a register with an outstanding result.
- Sits between decode/issue and the write-back stage.
- Holds one busy bit per architectural register and an in-flight write counter.
- Stalls issue on RAW, WAW or capacity hazards. Write-back clears busy bits.

---
 rtl/rf_scoreboard.sv | 91 +++++++++
 tb/tb_rf_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: one busy bit per architectural register plus an
// in-flight write counter, stalling issue on RAW, WAW and capacity hazards.
module rf_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             issue_use_rs,
    input  logic             issue_use_rt,
    input  logic             issue_we,
    input  logic [4:0]       issue_rd,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             stall,
    output logic             issue_fire,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic             spurious_wb
);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spur_q, spur_d;

    logic [31:0]      wb_clr;
    logic [31:0]      eff_busy;
    logic             any_clr;
    logic             raw, waw, full, set;
    logic [CNT_W-1:0] cnt_after_wb;

    // Per-register clear and next-state; register 0 is hard-wired idle.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wb_clr[gi] = 1'b0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_nz
                assign wb_clr[gi] = wb_valid & (wb_rd == 5'(gi)) & busy_q[gi];
                always_comb begin
                    busy_d[gi] = busy_q[gi];
                    if (flush)
                        busy_d[gi] = 1'b0;
                    else if (set && (issue_rd == 5'(gi)))
                        busy_d[gi] = 1'b1;
                    else if (wb_clr[gi])
                        busy_d[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Write-back is visible to hazard checks in the same cycle because the
    // register file writes through.
    assign eff_busy = busy_q & ~wb_clr;
    assign any_clr  = |wb_clr;

    always_comb begin
        cnt_after_wb = cnt_q - CNT_W'(any_clr);
        raw  = (issue_use_rs & eff_busy[issue_rs]) | (issue_use_rt & eff_busy[issue_rt]);
        waw  = issue_we & (issue_rd != 5'd0) & eff_busy[issue_rd];
        full = issue_we & (issue_rd != 5'd0) & (cnt_after_wb >= CNT_W'(MAX_INFLIGHT));
        stall      = issue_valid & (raw | waw | full);
        issue_fire = issue_valid & ~stall & ~flush;
        set        = issue_fire & issue_we & (issue_rd != 5'd0);

        cnt_d = flush ? '0 : (cnt_q + CNT_W'(set) - CNT_W'(any_clr));
        spur_d = wb_valid & (wb_rd != 5'd0) & ~busy_q[wb_rd] & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            spur_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            spur_q <= spur_d;
        end
    end

    assign busy_mask    = busy_q;
    assign inflight_cnt = cnt_q;
    assign spurious_wb  = spur_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed, table-driven bench for rf_scoreboard: per-cycle vectors plus
// hand-written sequences for asynchronous reset.
module tb_rf_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_use_rs;
    logic        issue_use_rt;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy_mask;
    logic [2:0]  inflight_cnt;
    logic        spurious_wb;

    rf_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall        (stall),
        .issue_fire   (issue_fire),
        .busy_mask    (busy_mask),
        .inflight_cnt (inflight_cnt),
        .spurious_wb  (spurious_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic        urs;
        logic [4:0]  rs;
        logic        urt;
        logic [4:0]  rt;
        logic        we;
        logic [4:0]  rd;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        e_stall;
        logic        e_fire;
        logic [31:0] e_busy;
        logic [2:0]  e_cnt;
        logic        e_spur;
    } vec_t;

    vec_t vq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive_idle();
        flush = 0; issue_valid = 0; issue_use_rs = 0; issue_rs = 0;
        issue_use_rt = 0; issue_rt = 0; issue_we = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        flush = t.fl; issue_valid = t.iv;
        issue_use_rs = t.urs; issue_rs = t.rs;
        issue_use_rt = t.urt; issue_rt = t.rt;
        issue_we = t.we; issue_rd = t.rd;
        wb_valid = t.wbv; wb_rd = t.wbrd;
        #1;
        check($sformatf("v%0d_stall", idx), {31'd0, stall}, {31'd0, t.e_stall});
        check($sformatf("v%0d_fire", idx), {31'd0, issue_fire}, {31'd0, t.e_fire});
        @(posedge clk);
        #1;
        check($sformatf("v%0d_busy", idx), busy_mask, t.e_busy);
        check($sformatf("v%0d_cnt", idx), {29'd0, inflight_cnt}, {29'd0, t.e_cnt});
        check($sformatf("v%0d_spur", idx), {31'd0, spurious_wb}, {31'd0, t.e_spur});
        $display("vec %0d: stall=%0b fire=%0b busy=0x%08h cnt=%0d spur=%0b",
                 idx, t.e_stall, t.e_fire, busy_mask, inflight_cnt, spurious_wb);
    endtask

    initial begin
        // fl iv urs rs urt rt we rd wbv wbrd | stall fire busy cnt spur
        vq.push_back('{0,1,0,0, 0,0, 1,5, 0,0, 0,1,32'h0000_0020,3'd1,0}); // 0 issue r5
        vq.push_back('{0,1,1,5, 0,0, 0,0, 0,0, 1,0,32'h0000_0020,3'd1,0}); // 1 RAW r5
        vq.push_back('{0,1,1,5, 0,0, 0,0, 1,5, 0,1,32'h0000_0000,3'd0,0}); // 2 wb r5 same cycle
        vq.push_back('{0,1,0,0, 0,0, 1,1, 0,0, 0,1,32'h0000_0002,3'd1,0}); // 3
        vq.push_back('{0,1,0,0, 0,0, 1,2, 0,0, 0,1,32'h0000_0006,3'd2,0}); // 4
        vq.push_back('{0,1,0,0, 0,0, 1,3, 0,0, 0,1,32'h0000_000E,3'd3,0}); // 5
        vq.push_back('{0,1,0,0, 0,0, 1,4, 0,0, 0,1,32'h0000_001E,3'd4,0}); // 6
        vq.push_back('{0,1,0,0, 0,0, 1,6, 0,0, 1,0,32'h0000_001E,3'd4,0}); // 7 full
        vq.push_back('{0,1,0,0, 0,0, 1,6, 1,1, 0,1,32'h0000_005C,3'd4,0}); // 8 full relieved by wb r1
        vq.push_back('{0,0,0,0, 0,0, 0,0, 1,2, 0,0,32'h0000_0058,3'd3,0}); // 9
        vq.push_back('{0,0,0,0, 0,0, 0,0, 1,3, 0,0,32'h0000_0050,3'd2,0}); // 10
        vq.push_back('{0,0,0,0, 0,0, 0,0, 1,4, 0,0,32'h0000_0040,3'd1,0}); // 11
        vq.push_back('{0,1,0,0, 0,0, 1,7, 0,0, 0,1,32'h0000_00C0,3'd2,0}); // 12
        vq.push_back('{0,1,0,0, 0,0, 1,7, 1,7, 0,1,32'h0000_00C0,3'd2,0}); // 13 set beats clear
        vq.push_back('{0,0,0,0, 0,0, 0,0, 1,9, 0,0,32'h0000_00C0,3'd2,1}); // 14 spurious wb r9
        vq.push_back('{0,0,0,0, 0,0, 0,0, 0,0, 0,0,32'h0000_00C0,3'd2,0}); // 15 pulse ends
        vq.push_back('{0,0,0,0, 0,0, 0,0, 1,0, 0,0,32'h0000_00C0,3'd2,0}); // 16 wb r0 silent
        vq.push_back('{0,1,1,6, 0,0, 1,8, 0,0, 1,0,32'h0000_00C0,3'd2,0}); // 17 RAW r6
        vq.push_back('{0,1,0,0, 0,0, 1,7, 0,0, 1,0,32'h0000_00C0,3'd2,0}); // 18 WAW r7
        vq.push_back('{0,0,0,0, 0,0, 0,0, 1,6, 0,0,32'h0000_0080,3'd1,0}); // 19
        vq.push_back('{0,0,0,0, 0,0, 0,0, 1,7, 0,0,32'h0000_0000,3'd0,0}); // 20
        vq.push_back('{0,1,1,0, 0,0, 1,0, 0,0, 0,1,32'h0000_0000,3'd0,0}); // 21 r0 never busy
        vq.push_back('{0,1,0,0, 0,0, 1,1, 0,0, 0,1,32'h0000_0002,3'd1,0}); // 22
        vq.push_back('{0,1,0,0, 0,0, 1,2, 0,0, 0,1,32'h0000_0006,3'd2,0}); // 23
        vq.push_back('{0,1,0,0, 0,0, 1,3, 0,0, 0,1,32'h0000_000E,3'd3,0}); // 24
        vq.push_back('{0,1,0,0, 1,3, 1,10,0,0, 1,0,32'h0000_000E,3'd3,0}); // 25 RAW via rt
        vq.push_back('{0,1,0,1, 0,0, 0,0, 0,0, 0,1,32'h0000_000E,3'd3,0}); // 26 rs busy but unused
        vq.push_back('{1,1,0,0, 0,0, 1,8, 1,9, 0,0,32'h0000_0000,3'd0,0}); // 27 flush

        rst_n = 1'b0;
        drive_idle();
        #12;
        check("reset_busy", busy_mask, 32'h0);
        check("reset_cnt", {29'd0, inflight_cnt}, 32'd0);
        check("reset_spur", {31'd0, spurious_wb}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        $display("reset: busy=0x%08h cnt=%0d", busy_mask, inflight_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) apply(vq[i], i);

        // Asynchronous reset mid-cycle with r2 busy and a spurious pulse live.
        @(negedge clk);
        drive_idle();
        issue_valid = 1; issue_we = 1; issue_rd = 2; wb_valid = 1; wb_rd = 9;
        @(posedge clk);
        #1;
        drive_idle();
        check("pre_rst_busy", busy_mask, 32'h0000_0004);
        check("pre_rst_spur", {31'd0, spurious_wb}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy_mask, 32'h0);
        check("async_rst_cnt", {29'd0, inflight_cnt}, 32'd0);
        check("async_rst_spur", {31'd0, spurious_wb}, 32'd0);
        $display("async reset: busy=0x%08h cnt=%0d spur=%0b", busy_mask, inflight_cnt, spurious_wb);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset behaves as from empty.
        apply('{0,1,0,0, 0,0, 1,2, 0,0, 0,1,32'h0000_0004,3'd1,0}, 100);

        @(negedge clk);
        drive_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
